// File: rtl/sinc3_trip_mc.sv
// Multi-channel sinc3 decimator with window comparator and k-of-n sticky trip.
// Drives the active-low PWM fault input from the per-channel trip status.
module sinc3_trip_mc #(
  parameter int NCH     = 4,
  parameter int ACC_W   = 24,
  parameter int DEC_W   = 16,
  parameter int WIN_MAX = 16,
  parameter int CW      = $clog2(WIN_MAX + 1)
) (
  input  logic                 mclk_trip,
  input  logic                 reset_trip,
  input  logic [NCH-1:0]       mdata_trip,
  input  logic [DEC_W-1:0]     dec_rate_trip,
  input  logic [NCH-1:0]       en_trip,
  input  logic [ACC_W-1:0]     lmax_trip,
  input  logic [ACC_W-1:0]     lmin_trip,
  input  logic [CW-1:0]        lcnt_trip,
  input  logic [CW-1:0]        lwin_trip,
  input  logic [NCH-1:0]       trip_clr,
  output logic [NCH*ACC_W-1:0] filter_out_trip,
  output logic                 data_valid,
  output logic [NCH-1:0]       limit_flags,
  output logic [NCH-1:0]       trip_status,
  output logic                 trip_pin
);

  logic [DEC_W-1:0] deff;
  logic [DEC_W-1:0] cnt_q, cnt_d;
  logic [1:0]       settle_q, settle_d;
  logic             dec_tick;
  logic             data_valid_q, data_valid_d;
  logic [NCH-1:0]   limit_flags_q, limit_flags_d;
  logic [NCH-1:0]   trip_status_q, trip_status_d;
  logic             trip_pin_q, trip_pin_d;
  logic             win_len_ok;

  // Shared decimation counter; the first three ticks only prime the combs.
  always_comb begin
    deff         = (dec_rate_trip < DEC_W'(2)) ? DEC_W'(2) : dec_rate_trip;
    dec_tick     = (cnt_q >= (deff - DEC_W'(1)));
    cnt_d        = dec_tick ? '0 : cnt_q + DEC_W'(1);
    settle_d     = settle_q;
    data_valid_d = 1'b0;
    if (dec_tick) begin
      if (settle_q == 2'd3) begin
        data_valid_d = 1'b1;
      end else begin
        settle_d = settle_q + 2'd1;
      end
    end
    win_len_ok = (lwin_trip != '0) && (lwin_trip <= CW'(WIN_MAX));
    trip_pin_d = ~|trip_status_d;
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [ACC_W-1:0]   i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [ACC_W-1:0]   z1_q, z1_d, z2_q, z2_d, z3_q, z3_d;
    logic [ACC_W-1:0]   out_q, out_d;
    logic [ACC_W-1:0]   c1, c2, c3;
    logic [WIN_MAX-1:0] win_q, win_d;
    logic [CW-1:0]      count;
    logic               exceed;
    logic               set_trip;

    always_comb begin
      // Modulo arithmetic throughout: integrator wrap cancels in the combs.
      i1_d  = i1_q + {{(ACC_W-1){1'b0}}, mdata_trip[gi]};
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      c1    = i3_q - z1_q;
      c2    = c1 - z2_q;
      c3    = c2 - z3_q;
      z1_d  = z1_q;
      z2_d  = z2_q;
      z3_d  = z3_q;
      out_d = out_q;
      if (dec_tick) begin
        z1_d  = i3_q;
        z2_d  = c1;
        z3_d  = c2;
        out_d = c3;
      end

      exceed = (out_q > lmax_trip) || (out_q < lmin_trip);
      win_d  = data_valid_q ? {win_q[WIN_MAX-2:0], exceed} : win_q;

      count = '0;
      if (win_len_ok) begin
        for (int b = 0; b < WIN_MAX; b++) begin
          if (CW'(b) < lwin_trip) begin
            count = count + CW'(win_q[b]);
          end
        end
      end
      set_trip = en_trip[gi] && (lcnt_trip != '0) && (count >= lcnt_trip);
    end

    assign limit_flags_d[gi] = data_valid_q ? exceed : limit_flags_q[gi];
    // Set dominates a simultaneous clear.
    assign trip_status_d[gi] = set_trip | (trip_status_q[gi] & ~trip_clr[gi]);
    assign filter_out_trip[gi*ACC_W +: ACC_W] = out_q;

    always_ff @(posedge mclk_trip or posedge reset_trip) begin
      if (reset_trip) begin
        i1_q  <= '0;
        i2_q  <= '0;
        i3_q  <= '0;
        z1_q  <= '0;
        z2_q  <= '0;
        z3_q  <= '0;
        out_q <= '0;
        win_q <= '0;
      end else begin
        i1_q  <= i1_d;
        i2_q  <= i2_d;
        i3_q  <= i3_d;
        z1_q  <= z1_d;
        z2_q  <= z2_d;
        z3_q  <= z3_d;
        out_q <= out_d;
        win_q <= win_d;
      end
    end
  end

  always_ff @(posedge mclk_trip or posedge reset_trip) begin
    if (reset_trip) begin
      cnt_q         <= '0;
      settle_q      <= '0;
      data_valid_q  <= 1'b0;
      limit_flags_q <= '0;
      trip_status_q <= '0;
      trip_pin_q    <= 1'b1;
    end else begin
      cnt_q         <= cnt_d;
      settle_q      <= settle_d;
      data_valid_q  <= data_valid_d;
      limit_flags_q <= limit_flags_d;
      trip_status_q <= trip_status_d;
      trip_pin_q    <= trip_pin_d;
    end
  end

  assign data_valid  = data_valid_q;
  assign limit_flags = limit_flags_q;
  assign trip_status = trip_status_q;
  assign trip_pin    = trip_pin_q;

endmodule

// File: tb/tb_sinc3_trip_mc.sv
// Scoreboard bench for sinc3_trip_mc: kernel-sum reference model feeds a queue,
// a negedge monitor pops and compares whenever the DUT presents a word.
module tb_sinc3_trip_mc;
  localparam int NCH     = 2;
  localparam int ACC_W   = 24;
  localparam int DEC_W   = 16;
  localparam int WIN_MAX = 16;
  localparam int CW      = $clog2(WIN_MAX + 1);
  localparam longint MASK = (64'sd1 <<< ACC_W) - 1;

  logic                 mclk_trip = 1'b0;
  logic                 reset_trip = 1'b1;
  logic [NCH-1:0]       mdata_trip = '0;
  logic [DEC_W-1:0]     dec_rate_trip = 16'd32;
  logic [NCH-1:0]       en_trip = '0;
  logic [ACC_W-1:0]     lmax_trip = '1;
  logic [ACC_W-1:0]     lmin_trip = '0;
  logic [CW-1:0]        lcnt_trip = '0;
  logic [CW-1:0]        lwin_trip = '0;
  logic [NCH-1:0]       trip_clr = '0;
  logic [NCH*ACC_W-1:0] filter_out_trip;
  logic                 data_valid;
  logic [NCH-1:0]       limit_flags;
  logic [NCH-1:0]       trip_status;
  logic                 trip_pin;

  sinc3_trip_mc #(.NCH(NCH), .ACC_W(ACC_W), .DEC_W(DEC_W), .WIN_MAX(WIN_MAX)) dut (
    .mclk_trip(mclk_trip), .reset_trip(reset_trip), .mdata_trip(mdata_trip),
    .dec_rate_trip(dec_rate_trip), .en_trip(en_trip), .lmax_trip(lmax_trip),
    .lmin_trip(lmin_trip), .lcnt_trip(lcnt_trip), .lwin_trip(lwin_trip),
    .trip_clr(trip_clr), .filter_out_trip(filter_out_trip), .data_valid(data_valid),
    .limit_flags(limit_flags), .trip_status(trip_status), .trip_pin(trip_pin)
  );

  always #5 mclk_trip = ~mclk_trip;

  int checks = 0;
  int failures = 0;
  int mode = 0;

  // Reference model state: raw input history, comb-input samples per tick,
  // exceed history (newest first), expected-word queue.
  bit                   xs[NCH][$];
  longint               ys[NCH][$];
  bit                   win_m[NCH][$];
  logic [NCH*ACC_W-1:0] exp_q[$];
  logic [NCH*ACC_W-1:0] last_word;
  int                   e_m, cnt_m, nt_m;
  bit                   dv_m, pin_m;
  logic [NCH-1:0]       status_m, lf_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int ch = 0; ch < NCH; ch++) begin
      xs[ch].delete();
      ys[ch].delete();
      win_m[ch].delete();
    end
    exp_q.delete();
    e_m = 0; cnt_m = 0; nt_m = 0; dv_m = 0;
    status_m = '0; lf_m = '0; pin_m = 1; last_word = '0;
  endfunction

  // Comb input at tick edge t: triple running sum of the bitstream, whose
  // weight for a sample s is m(m+1)/2 with m = t-2-s.
  function automatic longint ycalc(int ch, int t);
    longint acc = 0;
    for (int s = 0; s <= t - 2; s++) begin
      if (xs[ch][s]) begin
        longint m = longint'(t - 2 - s);
        acc += m * (m + 1) / 2;
      end
    end
    return acc & MASK;
  endfunction

  task automatic model_step();
    logic [NCH-1:0]       status_n;
    logic [NCH*ACC_W-1:0] word;
    int  deff, lw, cnt;
    bit  tick, dv_n, ex;
    for (int ch = 0; ch < NCH; ch++) begin
      lw = int'(lwin_trip);
      cnt = 0;
      if (lw >= 1 && lw <= WIN_MAX)
        for (int i = 0; i < lw && i < win_m[ch].size(); i++) cnt += int'(win_m[ch][i]);
      status_n[ch] = (en_trip[ch] && lcnt_trip != 0 && cnt >= int'(lcnt_trip)) ||
                     (status_m[ch] && !trip_clr[ch]);
    end
    if (dv_m) begin
      for (int ch = 0; ch < NCH; ch++) begin
        ex = (last_word[ch*ACC_W +: ACC_W] > lmax_trip) || (last_word[ch*ACC_W +: ACC_W] < lmin_trip);
        win_m[ch].push_front(ex);
        if (win_m[ch].size() > WIN_MAX) void'(win_m[ch].pop_back());
        lf_m[ch] = ex;
      end
    end
    for (int ch = 0; ch < NCH; ch++) xs[ch].push_back(mdata_trip[ch]);
    deff = (dec_rate_trip < 2) ? 2 : int'(dec_rate_trip);
    tick = (cnt_m >= deff - 1);
    cnt_m = tick ? 0 : cnt_m + 1;
    dv_n = 0;
    if (tick) begin
      nt_m++;
      for (int ch = 0; ch < NCH; ch++) ys[ch].push_back(ycalc(ch, e_m));
      if (nt_m >= 4) begin
        for (int ch = 0; ch < NCH; ch++) begin
          int n = ys[ch].size();
          longint w = ys[ch][n-1] - 3 * ys[ch][n-2] + 3 * ys[ch][n-3] - ys[ch][n-4];
          word[ch*ACC_W +: ACC_W] = ACC_W'(w & MASK);
        end
        exp_q.push_back(word);
        last_word = word;
        dv_n = 1;
      end
    end
    dv_m = dv_n;
    status_m = status_n;
    pin_m = ~|status_n;
    e_m++;
  endtask

  always @(posedge mclk_trip) begin
    if (!reset_trip) model_step();
  end

  // Monitor
  always @(negedge mclk_trip) begin
    if (!reset_trip) begin
      logic [NCH*ACC_W-1:0] w;
      chk("data_valid", data_valid, dv_m);
      if (data_valid || dv_m) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL word_queue: got data_valid with 0 expected words queued, required 1 (t=%0t)", $time);
        end else begin
          w = exp_q.pop_front();
          for (int ch = 0; ch < NCH; ch++)
            chk($sformatf("filter_out[%0d]", ch), filter_out_trip[ch*ACC_W +: ACC_W], w[ch*ACC_W +: ACC_W]);
        end
      end
      chk("limit_flags", limit_flags, lf_m);
      chk("trip_status", trip_status, status_m);
      chk("trip_pin", trip_pin, pin_m);
    end
  end

  // Bitstream driver
  initial forever begin
    @(posedge mclk_trip); #1;
    case (mode)
      0: mdata_trip = 2'b01;
      1: mdata_trip = {1'($urandom), ~mdata_trip[0]};
      default: mdata_trip = 2'($urandom);
    endcase
  end

  task automatic do_reset();
    @(posedge mclk_trip); #2;
    reset_trip = 1'b1;
    model_clear();
    #1;
    chk("rst_filter_out", filter_out_trip, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_limit_flags", limit_flags, 0);
    chk("rst_trip_status", trip_status, 0);
    chk("rst_trip_pin", trip_pin, 1);
    repeat (2) @(posedge mclk_trip);
    #1 reset_trip = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int got = 0, cyc = 0;
    while (got < n && cyc < 5000) begin
      @(negedge mclk_trip);
      cyc++;
      if (data_valid) got++;
    end
    checks++;
    if (got < n) begin
      failures++;
      $display("FAIL wait_words: got %0d words required %0d", got, n);
    end
  endtask

  task automatic cfg(input int d, input int lmax, input int lmin, input int lw, input int lc, input int en);
    dec_rate_trip = DEC_W'(d);
    lmax_trip = ACC_W'(lmax);
    lmin_trip = ACC_W'(lmin);
    lwin_trip = CW'(lw);
    lcnt_trip = CW'(lc);
    en_trip = NCH'(en);
  endtask

  task automatic run_pattern(input bit pat[$]);
    foreach (pat[i]) begin
      lmax_trip = pat[i] ? ACC_W'(20000) : ACC_W'(40000);
      wait_words(1);
      @(posedge mclk_trip); #1;
    end
  endtask

  initial begin
    // Steady-state gain, D=32
    mode = 0; cfg(32, 'hFFFFFF, 0, 4, 0, 3); do_reset();
    wait_words(6);
    chk("gain_ch0", filter_out_trip[0 +: ACC_W], 32768);
    chk("gain_ch1", filter_out_trip[ACC_W +: ACC_W], 0);
    // Alternating input
    mode = 1; do_reset();
    wait_words(5);
    chk("alt_ch0", filter_out_trip[0 +: ACC_W], 16384);
    // D=1 treated as 2
    mode = 0; cfg(1, 'hFFFFFF, 0, 4, 0, 3); do_reset();
    wait_words(5);
    chk("d1_ch0", filter_out_trip[0 +: ACC_W], 8);
    // Trip timing
    cfg(32, 20000, 0, 4, 3, 1); do_reset();
    wait_words(3);
    @(negedge mclk_trip); chk("trip_pre", trip_status[0], 0);
    @(negedge mclk_trip); chk("trip_rise", trip_status[0], 1);
    chk("trip_pin_fall", trip_pin, 0);
    chk("trip_ch1", trip_status[1], 0);
    // k-of-n patterns
    cfg(32, 20000, 0, 4, 3, 1); do_reset();
    run_pattern('{1, 0, 1, 0, 1});
    repeat (3) @(negedge mclk_trip);
    chk("kofn_10101", trip_status[0], 0);
    do_reset();
    run_pattern('{1, 0, 1, 1});
    @(negedge mclk_trip); chk("kofn_1011_pre", trip_status[0], 0);
    @(negedge mclk_trip); chk("kofn_1011", trip_status[0], 1);
    // Disables, then late enable
    cfg(32, 20000, 0, 4, 0, 1); do_reset(); wait_words(6);
    chk("dis_lcnt0", trip_status[0], 0);
    cfg(32, 20000, 0, 0, 3, 1); do_reset(); wait_words(6);
    chk("dis_lwin0", trip_status[0], 0);
    cfg(32, 20000, 0, 4, 3, 0); do_reset(); wait_words(6);
    chk("dis_en0", trip_status[0], 0);
    @(posedge mclk_trip); #1 en_trip = 2'b01;
    @(negedge mclk_trip); chk("en_rise_pre", trip_status[0], 0);
    @(negedge mclk_trip); chk("en_rise", trip_status[0], 1);
    // Clear while exceed persists, then after window drains
    @(posedge mclk_trip); #1 trip_clr = 2'b01;
    @(posedge mclk_trip); #1 trip_clr = 2'b00;
    @(negedge mclk_trip); chk("clr_set_wins", trip_status[0], 1);
    lmax_trip = '1;
    wait_words(4);
    @(posedge mclk_trip); #1 trip_clr = 2'b01;
    @(posedge mclk_trip); #1 trip_clr = 2'b00;
    @(negedge mclk_trip); chk("clr_drained", trip_status[0], 0);
    chk("clr_pin", trip_pin, 1);
    // Mid-run reset, settling repeats
    cfg(32, 20000, 0, 4, 2, 3); do_reset(); wait_words(2);
    do_reset(); wait_words(4);
    // Randomised runs: random bits, limits, window settings, D changes
    mode = 2;
    for (int r = 0; r < 4; r++) begin
      int d = $urandom_range(1, 24);
      cfg(d, $urandom_range(0, d*d*d), $urandom_range(0, d*d*d/2), $urandom_range(0, 20),
          $urandom_range(0, 4), $urandom_range(0, 3));
      do_reset();
      for (int w = 0; w < 12; w++) begin
        int dd = (dec_rate_trip < 2) ? 2 : int'(dec_rate_trip);
        lmax_trip = ACC_W'($urandom_range(0, dd*dd*dd));
        lmin_trip = ACC_W'($urandom_range(0, dd*dd*dd/2));
        lwin_trip = CW'($urandom_range(0, 20));
        lcnt_trip = CW'($urandom_range(0, 4));
        en_trip   = NCH'($urandom_range(0, 3));
        trip_clr  = NCH'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) dec_rate_trip = DEC_W'($urandom_range(1, 24));
        @(posedge mclk_trip); #1 trip_clr = '0;
        wait_words(1);
        @(posedge mclk_trip); #1;
      end
    end
    repeat (4) @(posedge mclk_trip);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
